mips_multicycle_ctrl: RTL

//  Control unit for the multicycle MIPS core; pairs with the datapath.

---
 rtl/mips_decls_p.sv | 53 +++++
 rtl/mips_aludec.sv | 30 +++
 rtl/mips_multicycle_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mips_decls_p.sv
// Shared declarations for the multicycle MIPS core: ISA field encodings,
// control FSM states and ALU operation classes.
package mips_decls_p;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_BNE   = 6'b000101,
    OP_ADDI  = 6'b001000,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_t;

  typedef enum logic [5:0] {
    F_ADD = 6'b100000,
    F_SUB = 6'b100010,
    F_AND = 6'b100100,
    F_OR  = 6'b100101,
    F_SLT = 6'b101010
  } funct_t;

  // BNEEX is always part of the encoding so the state width never depends on
  // the build configuration.
  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    RTYPEEX,
    RTYPEWB,
    BEQEX,
    ADDIEX,
    ADDIWB,
    JEX,
    BNEEX
  } statetype_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } aluop_t;

  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_SLT = 3'b111;

endpackage

// File: rtl/mips_aludec.sv
// ALU decoder: maps the FSM's aluop class plus the R-type funct field onto
// the 3-bit ALU control code. Purely combinational.
module mips_aludec
  import mips_decls_p::*;
(
  input  aluop_t     aluop,
  input  funct_t     funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALUC_ADD;
    case (aluop)
      ALU_ADD: alucontrol = ALUC_ADD;
      ALU_SUB: alucontrol = ALUC_SUB;
      ALU_FUNCT: begin
        case (funct)
          F_ADD:   alucontrol = ALUC_ADD;
          F_SUB:   alucontrol = ALUC_SUB;
          F_AND:   alucontrol = ALUC_AND;
          F_OR:    alucontrol = ALUC_OR;
          F_SLT:   alucontrol = ALUC_SLT;
          default: alucontrol = ALUC_ADD;
        endcase
      end
      default: alucontrol = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM plus ALU decoder.
// Optional build macro MIPS_CTRL_BNE_EN adds the BNE instruction.
module mips_multicycle_ctrl
  import mips_decls_p::*;
(
  input  logic       clk,
  input  logic       reset,
  input  opcode_t    opcode,
  input  funct_t     funct,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       alusrca,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol
);

  statetype_t state, nextstate;
  aluop_t     aluop;
  logic       pcwrite, branch, brtaken;
  logic       irwrite_s, regwrite_s, memwrite_s;
`ifdef MIPS_CTRL_BNE_EN
  logic       bnebranch;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= nextstate;
  end

  always_comb begin
    nextstate  = FETCH;
    pcwrite    = 1'b0;
    branch     = 1'b0;
`ifdef MIPS_CTRL_BNE_EN
    bnebranch  = 1'b0;
`endif
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    memwrite_s = 1'b0;
    alusrca    = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = ALU_ADD;
    case (state)
      FETCH: begin
        nextstate = DECODE;
        irwrite_s = 1'b1;
        pcwrite   = 1'b1;
        alusrcb   = 2'b01;
      end
      DECODE: begin
        // Branch target is precomputed here so BEQEX/BNEEX can use ALUOut.
        alusrcb = 2'b11;
        case (opcode)
          OP_LW, OP_SW: nextstate = MEMADR;
          OP_RTYPE:     nextstate = RTYPEEX;
          OP_BEQ:       nextstate = BEQEX;
          OP_ADDI:      nextstate = ADDIEX;
          OP_J:         nextstate = JEX;
`ifdef MIPS_CTRL_BNE_EN
          OP_BNE:       nextstate = BNEEX;
`endif
          default:      nextstate = FETCH;
        endcase
      end
      MEMADR: begin
        nextstate = (opcode == OP_LW) ? MEMRD : MEMWR;
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
      end
      MEMRD: begin
        nextstate = MEMWB;
        iord      = 1'b1;
      end
      MEMWB: begin
        regwrite_s = 1'b1;
        memtoreg   = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      RTYPEEX: begin
        nextstate = RTYPEWB;
        alusrca   = 1'b1;
        aluop     = ALU_FUNCT;
      end
      RTYPEWB: begin
        regwrite_s = 1'b1;
        regdst     = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALU_SUB;
        branch  = 1'b1;
        pcsrc   = 2'b01;
      end
      ADDIEX: begin
        nextstate = ADDIWB;
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
      end
      ADDIWB: regwrite_s = 1'b1;
      JEX: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
      end
      BNEEX: begin
        alusrca   = 1'b1;
        aluop     = ALU_SUB;
        pcsrc     = 2'b01;
`ifdef MIPS_CTRL_BNE_EN
        bnebranch = 1'b1;
`endif
      end
      default: nextstate = FETCH;
    endcase
  end

`ifdef MIPS_CTRL_BNE_EN
  assign brtaken = (branch & zero) | (bnebranch & ~zero);
`else
  assign brtaken = branch & zero;
`endif

  // Write enables are suppressed during reset so a mid-instruction reset
  // cannot disturb architectural state.
  assign pcen     = ~reset & (pcwrite | brtaken);
  assign irwrite  = ~reset & irwrite_s;
  assign regwrite = ~reset & regwrite_s;
  assign memwrite = ~reset & memwrite_s;

  mips_aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule
